// File: rtl/kyber_sched_pkg.sv
// kyber_sched_pkg: shared state encoding and default timing constants for the inverse-NTT scheduler
package kyber_sched_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_ENG_RST,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_NEXT,
    S_RESP
  } intt_sched_state_t;
  localparam int INTT_RST_CYC = 2;
  localparam int INTT_TIMEOUT = 4096;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            hit
);
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!hit && req[j]) begin
        hit = 1'b1;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/intt_job_scheduler.sv
// intt_job_scheduler: round-robin sequencer running K-poly jobs through one shared inverse-NTT engine
module intt_job_scheduler
  import kyber_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int K = 3,
  parameter int RST_CYC = INTT_RST_CYC,
  parameter int TIMEOUT = INTT_TIMEOUT,
  localparam int SW = $clog2(NREQ),
  localparam int PW = $clog2(K),
  localparam int WW = $clog2(TIMEOUT),
  localparam int CW = $clog2(RST_CYC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] resp_valid,
  output logic            resp_err,
  output logic            busy,
  output logic [SW-1:0]   eng_sel,
  output logic [PW-1:0]   poly_idx,
  output logic            eng_rst,
  output logic            eng_start,
  input  logic            eng_done,
  output logic            res_we
);
  intt_sched_state_t state, nxt;
  logic [SW-1:0] rr_ptr, gidx;
  logic [NREQ-1:0] gnt;
  logic hit, grant;
  logic [CW-1:0] rcnt;
  logic [WW-1:0] wd;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx),
    .hit(hit)
  );
  assign grant = state == S_ARB && hit;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = |req_valid ? S_ARB : S_IDLE;
      S_ARB:     nxt = hit ? S_ENG_RST : S_IDLE;
      S_ENG_RST: nxt = rcnt == CW'(RST_CYC - 1) ? S_START : S_ENG_RST;
      S_START:   nxt = S_WAIT;
      S_WAIT:    nxt = eng_done ? S_CAPTURE : wd == WW'(TIMEOUT - 1) ? S_RESP : S_WAIT;
      S_CAPTURE: nxt = S_NEXT;
      S_NEXT:    nxt = poly_idx == PW'(K - 1) ? S_RESP : S_ENG_RST;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      rcnt <= '0;
      wd <= '0;
      req_ready <= '0;
      resp_valid <= '0;
      resp_err <= 1'b0;
      busy <= 1'b0;
      eng_sel <= '0;
      poly_idx <= '0;
      eng_rst <= 1'b1;
      eng_start <= 1'b0;
      res_we <= 1'b0;
    end else begin
      state <= nxt;
      req_ready <= grant ? gnt : '0;
      eng_start <= nxt == S_START;
      res_we <= nxt == S_CAPTURE;
      resp_valid <= nxt == S_RESP ? NREQ'(1) << eng_sel : '0;
      resp_err <= state == S_WAIT && nxt == S_RESP;
      rcnt <= state == S_ENG_RST ? rcnt + CW'(1) : '0;
      wd <= (state == S_START || state == S_WAIT) ? wd + WW'(1) : '0;
      busy <= grant ? 1'b1 : state == S_IDLE ? 1'b0 : busy;
      eng_rst <= (nxt == S_ENG_RST || nxt == S_RESP) ? 1'b1 : (state == S_IDLE || nxt == S_START) ? 1'b0 : eng_rst;
      if (grant) begin
        eng_sel <= gidx;
        poly_idx <= '0;
        rr_ptr <= gidx == SW'(NREQ - 1) ? '0 : gidx + SW'(1);
      end else if (state == S_NEXT && nxt == S_ENG_RST) begin
        poly_idx <= poly_idx + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_intt_job_scheduler.sv
// tb_intt_job_scheduler: directed and randomized job sequences checked against an event-level model
module tb_intt_job_scheduler;
  import kyber_sched_pkg::*;
  localparam int NREQ = 2;
  localparam int K = 3;
  localparam int RST_CYC = INTT_RST_CYC;
  localparam int TIMEOUT = INTT_TIMEOUT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready, resp_valid;
  logic resp_err, busy, eng_rst, eng_start, eng_done, res_we;
  logic [$clog2(NREQ)-1:0] eng_sel;
  logic [$clog2(K)-1:0] poly_idx;
  intt_job_scheduler #(.NREQ(NREQ), .K(K), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .busy(busy),
    .eng_sel(eng_sel),
    .poly_idx(poly_idx),
    .eng_rst(eng_rst),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .res_we(res_we)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // engine model: done rises lat[p] cycles after start, sticky until eng_rst; lat 0 = never
  int lat[K];
  int sc = 0;
  bit run = 1'b0, done_m = 1'b0, fdone = 1'b0, force_early = 1'b0;
  always @(negedge clk) begin
    if (rst || eng_rst) run = 1'b0;
    else if (eng_start) begin
      run = 1'b1;
      sc = cyc;
    end
    done_m = run && lat[int'(poly_idx)] != 0 && cyc >= sc + lat[int'(poly_idx)];
    fdone = force_early && (eng_rst || eng_start);
  end
  assign eng_done = done_m | fdone;
  typedef struct {int c; int a; int b; int r; int z;} ev_t;
  ev_t st_q[$], we_q[$], rs_q[$], rd_q[$];
  bit bz_h[int];
  int rrun = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) st_q.push_back('{cyc, int'(eng_sel), int'(poly_idx), rrun, int'(busy)});
      rrun = eng_rst ? rrun + 1 : 0;
      if (res_we) we_q.push_back('{cyc, int'(eng_sel), int'(poly_idx), 0, int'(busy)});
      if (|resp_valid) rs_q.push_back('{cyc, int'(resp_valid), int'(resp_err), int'(eng_rst), int'(busy)});
      if (|req_ready) rd_q.push_back('{cyc, int'(req_ready), 0, 0, int'(busy)});
      bz_h[cyc] = busy;
    end
  end
  int checks = 0, errs = 0;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic clr();
    st_q.delete();
    we_q.delete();
    rs_q.delete();
    rd_q.delete();
  endtask
  task automatic job(input int owner, input int pr, output int r);
    int n, exp_r;
    bit to;
    clr();
    r = cyc;
    for (int i = 0; i < 20 && rd_q.size() == 0; i++) tick();
    chk("grant_seen", rd_q.size(), 1);
    if (rd_q.size() == 0) return;
    chk("grant_vec", rd_q[0].a, 1 << owner);
    chk("busy_at_grant", rd_q[0].z, 1);
    if (pr >= 0) chk("turnaround", rd_q[0].c - pr, 3);
    req_valid[owner] = 1'b0;
    n = 0;
    while (n < K && lat[n] != 0) n++;
    to = n < K;
    for (int i = 0; i < 3 * TIMEOUT && rs_q.size() == 0; i++) tick();
    chk("resp_seen", rs_q.size(), 1);
    if (rs_q.size() == 0) return;
    r = rs_q[0].c;
    chk("start_count", st_q.size(), to ? n + 1 : K);
    chk("capture_count", we_q.size(), n);
    chk("grant_to_start", st_q[0].c - rd_q[0].c, RST_CYC);
    foreach (st_q[i]) begin
      chk("start_sel", st_q[i].a, owner);
      chk("start_idx", st_q[i].b, i);
      chk("rst_cycles", st_q[i].r, RST_CYC);
    end
    foreach (we_q[i]) begin
      chk("capture_time", we_q[i].c - st_q[i].c, lat[i] + 1);
      chk("capture_idx", we_q[i].b, i);
      chk("capture_sel", we_q[i].a, owner);
    end
    exp_r = to ? st_q[n].c + TIMEOUT : we_q[n-1].c + 2;
    chk("resp_time", r, exp_r);
    chk("resp_vec", rs_q[0].a, 1 << owner);
    chk("resp_err", rs_q[0].b, to);
    chk("eng_rst_in_resp", rs_q[0].r, 1);
    chk("busy_in_resp", rs_q[0].z, 1);
  endtask
  task automatic post(input int r);
    tick();
    tick();
    chk("busy_after_resp", bz_h[r+1], 1);
    chk("busy_drop", bz_h[r+2], 0);
    chk("single_resp", rs_q.size(), 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r, r2, owner, ptr, pr;
    logic [NREQ-1:0] pend;
    foreach (lat[i]) lat[i] = 10;
    repeat (3) tick();
    chk("reset_outputs", {req_ready, resp_valid, resp_err, busy, eng_sel, poly_idx, eng_start, res_we}, 0);
    chk("reset_eng_rst", eng_rst, 1);
    rst = 1'b0;
    tick();
    chk("idle_eng_rst", eng_rst, 0);
    // simultaneous requests, then requester 0 re-requests while 1 is pending
    lat = '{4, 9, 6};
    req_valid = 2'b11;
    job(0, -1, r);
    req_valid[0] = 1'b1;
    post(r);
    lat = '{7, 3, 12};
    job(1, r, r2);
    post(r2);
    lat = '{5, 5, 5};
    job(0, r2, r);
    post(r);
    // long engine latency
    lat = '{2100, 2100, 2100};
    req_valid = 2'b01;
    job(0, -1, r);
    post(r);
    // request withdrawn while in ARB
    clr();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    chk("no_grant_when_dropped", rd_q.size() + st_q.size(), 0);
    // early done during ENG_RST/START must be ignored
    force_early = 1'b1;
    lat = '{5, 7, 9};
    req_valid = 2'b10;
    job(1, -1, r);
    post(r);
    force_early = 1'b0;
    // engine never finishes poly 0, then poly 2
    lat = '{0, 5, 5};
    req_valid = 2'b01;
    job(0, -1, r);
    post(r);
    lat = '{3, 4, 0};
    req_valid = 2'b10;
    job(1, -1, r);
    post(r);
    // reset during WAIT of poly 1
    clr();
    lat = '{30, 30, 30};
    req_valid = 2'b01;
    for (int i = 0; i < 20 && rd_q.size() == 0; i++) tick();
    req_valid = 2'b00;
    for (int i = 0; i < 2000 && st_q.size() < 2; i++) tick();
    chk("reached_poly1", st_q.size(), 2);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midjob_reset_outputs", {req_ready, resp_valid, resp_err, busy, eng_sel, poly_idx, eng_start, res_we}, 0);
    chk("midjob_reset_eng_rst", eng_rst, 1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("job_lost_no_resp", rs_q.size(), 0);
    lat = '{6, 8, 4};
    req_valid = 2'b11;
    job(0, -1, r);
    post(r);
    job(1, -1, r);
    post(r);
    // randomized requests against a round-robin order model
    ptr = 0;
    pr = -1;
    pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int j = 0; j < 12; j++) begin
      owner = -1;
      for (int k = 0; k < NREQ; k++) if (owner < 0 && pend[(ptr + k) % NREQ]) owner = (ptr + k) % NREQ;
      foreach (lat[i]) lat[i] = $urandom_range(1, 50);
      req_valid = pend;
      job(owner, pr, r);
      pend[owner] = 1'b0;
      for (int k = 0; k < NREQ; k++) if (!pend[k] && $urandom_range(0, 1) == 1) pend[k] = 1'b1;
      if (pend == '0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
      req_valid = pend;
      ptr = (owner + 1) % NREQ;
      pr = r;
      post(r);
    end
    req_valid = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
